// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48A1-style MAC sequencer.
// Optional abort support is selected with DSP_SEQ_ABORT_EN (see dsp_mac_sequencer).
package dsp_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam logic [7:0] OPMODE_IDLE = 8'h00;
    localparam logic [7:0] OPMODE_LOAD = 8'h01;
    localparam logic [7:0] OPMODE_ACC  = 8'h09;

    typedef struct packed {
        logic valid;
        logic first;
    } entry_t;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Control/stream bundle between operand source, sequencer and slice control pins.
// The abort input exists only when DSP_SEQ_ABORT_EN is defined.
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic             ab_ce;
    logic             p_ce;
    logic             p_rst;
    logic [7:0]       opmode;
    logic             busy;
    logic             done;
`ifdef DSP_SEQ_ABORT_EN
    logic             abort;

    modport master (
        output start, len, in_valid, abort,
        input  in_ready, ab_ce, p_ce, p_rst, opmode, busy, done
    );
    modport slave (
        input  start, len, in_valid, abort,
        output in_ready, ab_ce, p_ce, p_rst, opmode, busy, done
    );
`else
    modport master (
        output start, len, in_valid,
        input  in_ready, ab_ce, p_ce, p_rst, opmode, busy, done
    );
    modport slave (
        input  start, len, in_valid,
        output in_ready, ab_ce, p_ce, p_rst, opmode, busy, done
    );
`endif
endinterface

// File: rtl/dsp_seq_delay.sv
// Control delay line matching the slice's operand-to-P latency.
// pending flags a valid entry anywhere except the output stage.
module dsp_seq_delay
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  entry_t din,
    output entry_t dout,
    output logic   pending
);

    entry_t line_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else begin
            line_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        end
    end

    assign dout = line_q[DEPTH-1];

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pending = pending | line_q[i].valid;
    end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequencer gating operand capture and P-register of a DSP48A1-style MAC slice.
// Define DSP_SEQ_ABORT_EN to add the abort input (flush, P clear, back to idle).
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int PIPE_LAT = 4,
    parameter int LEN_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dsp_mac_sequencer_if.slave   bus
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             p_rst_q, p_rst_d;
    logic             accept;
    logic             abort_hit;
    logic             pending;
    entry_t           push;
    entry_t           tail;

    assign accept = bus.in_valid & (state_q == StRun);

`ifdef DSP_SEQ_ABORT_EN
    assign abort_hit = bus.abort & ((state_q == StRun) | (state_q == StDrain));
`else
    assign abort_hit = 1'b0;
`endif

    assign push.valid = accept;
    assign push.first = accept & first_q;

    dsp_seq_delay #(
        .DEPTH (PIPE_LAT - 1)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort_hit),
        .din     (push),
        .dout    (tail),
        .pending (pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            first_q <= 1'b0;
            p_rst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            p_rst_q <= p_rst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        p_rst_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start && (bus.len != '0)) begin
                    cnt_d   = bus.len;
                    first_d = 1'b1;
                    p_rst_d = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    cnt_d   = cnt_q - LEN_W'(1);
                    first_d = 1'b0;
                    if (cnt_q == LEN_W'(1)) state_d = StDrain;
                end
            end
            // No pushes happen here, so the last valid is at the tail once nothing is pending.
            StDrain: begin
                if (tail.valid && !pending) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_hit) begin
            state_d = StIdle;
            first_d = 1'b0;
            p_rst_d = 1'b1;
        end
    end

    always_comb begin
        bus.in_ready = (state_q == StRun);
        bus.ab_ce    = bus.in_valid & (state_q == StRun);
        bus.busy     = (state_q != StIdle);
        bus.done     = (state_q == StDone);
        bus.p_rst    = p_rst_q;
        bus.p_ce     = tail.valid;
        if (!tail.valid)     bus.opmode = OPMODE_IDLE;
        else if (tail.first) bus.opmode = OPMODE_LOAD;
        else                 bus.opmode = OPMODE_ACC;
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Scoreboard bench for dsp_mac_sequencer with PIPE_LAT=4; expected P-stage events are
// queued by the stimulus and consumed by a negedge monitor.
module tb_dsp_mac_sequencer;

    localparam int KRST  = 0;
    localparam int KPCE  = 1;
    localparam int KDONE = 2;

    typedef struct {
        int         kind;
        int         at;
        logic [7:0] op;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];

    dsp_mac_sequencer_if #(.LEN_W(8)) bus ();

    dsp_mac_sequencer #(
        .PIPE_LAT (4),
        .LEN_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input int at, input logic [7:0] op);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.op   = op;
        exp_q.push_back(e);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, req);
        end
    endtask

    task automatic pop_cmp(input int kind, input logic [7:0] op);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind %0d at cycle %0d op %0h (none expected)",
                     kind, cyc, op);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cyc || e.op !== op) begin
                errors++;
                $display("FAIL event: got kind %0d cycle %0d op %0h, expected kind %0d cycle %0d op %0h",
                         kind, cyc, op, e.kind, e.at, e.op);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.p_rst) pop_cmp(KRST, 8'h00);
            if (bus.p_ce) pop_cmp(KPCE, bus.opmode);
            else check("opmode_idle", 32'(bus.opmode), 32'h00);
            if (bus.done) pop_cmp(KDONE, 8'h00);
            check("ab_ce", 32'(bus.ab_ce), 32'(bus.in_valid & bus.in_ready));
        end
    end

    function automatic logic [31:0] all_outs();
        return 32'({bus.in_ready, bus.ab_ce, bus.p_ce, bus.p_rst, bus.opmode, bus.busy, bus.done});
    endfunction

    initial begin
        int s;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
`ifdef DSP_SEQ_ABORT_EN
        bus.abort    = 1'b0;
`endif
        repeat (2) tick();
        check("reset_outputs", all_outs(), 32'h0);
        rst = 1'b0;
        tick();
        check("idle_outputs", all_outs(), 32'h0);

        // len=3, continuous source
        s = cyc;
        bus.start = 1'b1; bus.len = 8'd3; bus.in_valid = 1'b1;
        push_ev(KRST, s + 1, 8'h00);
        push_ev(KPCE, s + 4, 8'h01);
        push_ev(KPCE, s + 5, 8'h09);
        push_ev(KPCE, s + 6, 8'h09);
        push_ev(KDONE, s + 7, 8'h00);
        tick();
        bus.start = 1'b0;
        check("run_ready", 32'(bus.in_ready), 32'h1);
        check("run_busy", 32'(bus.busy), 32'h1);
        repeat (9) tick();
        bus.in_valid = 1'b0;
        tick();

        // len=4 with a source bubble in the second RUN cycle
        s = cyc;
        bus.start = 1'b1; bus.len = 8'd4; bus.in_valid = 1'b1;
        push_ev(KRST, s + 1, 8'h00);
        push_ev(KPCE, s + 4, 8'h01);
        push_ev(KPCE, s + 6, 8'h09);
        push_ev(KPCE, s + 7, 8'h09);
        push_ev(KPCE, s + 8, 8'h09);
        push_ev(KDONE, s + 9, 8'h00);
        tick();
        bus.start = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        tick();
        tick();
        check("gap_p_ce", 32'(bus.p_ce), 32'h0);
        check("gap_opmode", 32'(bus.opmode), 32'h00);
        repeat (6) tick();
        bus.in_valid = 1'b0;

        // len=0 is ignored
        bus.start = 1'b1; bus.len = 8'd0; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("len0_idle", 32'({bus.busy, bus.p_rst, bus.in_ready}), 32'h0);
        end
        bus.start = 1'b0; bus.in_valid = 1'b0;
        tick();

        // start during RUN and DONE ignored, then a normal job
        s = cyc;
        bus.start = 1'b1; bus.len = 8'd2; bus.in_valid = 1'b1;
        push_ev(KRST, s + 1, 8'h00);
        push_ev(KPCE, s + 4, 8'h01);
        push_ev(KPCE, s + 5, 8'h09);
        push_ev(KDONE, s + 6, 8'h00);
        push_ev(KRST, s + 9, 8'h00);
        push_ev(KPCE, s + 12, 8'h01);
        push_ev(KDONE, s + 13, 8'h00);
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1; bus.len = 8'd5;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.start = 1'b1; bus.len = 8'd7;
        check("done_during_start", 32'(bus.done), 32'h1);
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1; bus.len = 8'd1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        bus.in_valid = 1'b0;

        // reset after 2 of 5 beats
        s = cyc;
        bus.start = 1'b1; bus.len = 8'd5; bus.in_valid = 1'b1;
        push_ev(KRST, s + 1, 8'h00);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrun_reset_outputs", all_outs(), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        check("reset_no_pending", 32'(exp_q.size()), 32'h0);
        repeat (3) tick();
        s = cyc;
        bus.start = 1'b1; bus.len = 8'd2;
        push_ev(KRST, s + 1, 8'h00);
        push_ev(KPCE, s + 4, 8'h01);
        push_ev(KPCE, s + 5, 8'h09);
        push_ev(KDONE, s + 6, 8'h00);
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        bus.in_valid = 1'b0;

`ifdef DSP_SEQ_ABORT_EN
        // abort in DRAIN
        s = cyc;
        bus.start = 1'b1; bus.len = 8'd1; bus.in_valid = 1'b1;
        push_ev(KRST, s + 1, 8'h00);
        push_ev(KRST, s + 3, 8'h00);
        tick();
        bus.start = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        check("drain_busy", 32'({bus.busy, bus.in_ready}), 32'h2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_idle", 32'({bus.busy, bus.p_ce}), 32'h0);
        repeat (8) tick();
`endif

        repeat (5) tick();
        check("all_events_seen", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
